// File: rtl/sp_ram_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : sp_ram_bank_pkg                                                |
// | Purpose  : Shared types and helpers for the banked data memory:          |
// |            byte-address to bank/row decode, round-robin index helper,    |
// |            per-port response record and parameter sanity functions.      |
// | Ports    : none (package)                                                |
// | Options  : SP_RAM_BANK_PARITY_EN (used by sp_ram_bank_wrap)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sp_ram_bank_pkg;

   // Width of the rdata field carried in a response record.
   localparam int RESP_DW = 32;

   typedef struct packed {
      logic               valid;
      logic [RESP_DW-1:0] rdata;
      logic               err;
   } resp_t;

   // Bank index: low BB bits of the word address.
   function automatic logic [31:0] bank_sel(input logic [31:0] byte_addr,
                                            input int off, input int bb);
      logic [31:0] word;
      word = byte_addr >> off;
      return word & ((32'd1 << bb) - 32'd1);
   endfunction

   // Row inside a bank: word address with the bank bits stripped.
   function automatic logic [31:0] row_sel(input logic [31:0] byte_addr,
                                           input int off, input int bb);
      logic [31:0] word;
      word = byte_addr >> off;
      return word >> bb;
   endfunction

   // i-th candidate port when the search starts at ptr.
   function automatic int rr_idx(input int ptr, input int i, input int n);
      return (ptr + i) % n;
   endfunction

   function automatic bit lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 1) && ((n & (n - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sp_ram                                                        |
// | Purpose  : Single-port synchronous RAM, one-cycle read latency, write    |
// |            mask per lane. Contents are not reset.                        |
// | Ports    : clk, en, we, addr [AW], be [LANES],                           |
// |            wdata/rdata [LANES*LANE_W]                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sp_ram #(
   parameter  int NUM_WORDS = 2048,
   parameter  int LANES     = 4,
   parameter  int LANE_W    = 8,
   localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int W         = LANES * LANE_W
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [LANES-1:0] be,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [NUM_WORDS];

   // rdata only changes on reads, so a write leaves the last read word in place.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int k = 0; k < LANES; k++) begin
               if (be[k]) begin
                  mem[addr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sp_ram_bank_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sp_ram_bank_arb                                               |
// | Purpose  : Round-robin arbiter for one bank. Grants at most one of       |
// |            NUM_PORTS requesters per cycle; the pointer moves to          |
// |            winner+1 after every grant and resets to port 0.              |
// | Ports    : clk, rst_i (async, active-high)                               |
// |            req     [NUM_PORTS]  requests targeting this bank             |
// |            gnt     [NUM_PORTS]  one-hot grant (combinational)            |
// |            winner  [PW]         index of the granted port                |
// |            granted              any grant this cycle                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sp_ram_bank_arb
   import sp_ram_bank_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [PW-1:0]        winner,
   output logic                 granted
);

   logic [PW-1:0] ptr;

   // Scan ports starting at the pointer; the first requester wins.
   always_comb begin
      gnt     = '0;
      winner  = '0;
      granted = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!granted && req[PW'(rr_idx(int'(ptr), i, NUM_PORTS))]) begin
            granted = 1'b1;
            gnt[PW'(rr_idx(int'(ptr), i, NUM_PORTS))] = 1'b1;
            winner  = PW'(rr_idx(int'(ptr), i, NUM_PORTS));
         end
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (granted) begin
         ptr <= PW'(rr_idx(int'(winner), 1, NUM_PORTS));
      end
   end

endmodule
`default_nettype wire

// File: rtl/sp_ram_bank_wrap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sp_ram_bank_wrap                                              |
// | Purpose  : Multi-port, word-interleaved banked data memory. NUM_PORTS    |
// |            masters share NUM_BANKS single-port banks with per-bank       |
// |            round-robin arbitration and a req/gnt/rvalid handshake.       |
// |            Every accepted request yields one rvalid pulse RD_LAT (1|2)   |
// |            cycles later; write responses carry rdata = 0.                |
// | Ports    : clk, rst_i (async, active-high)                               |
// |            req_i/gnt_o/we_i/rvalid_o/err_o   [NUM_PORTS]                 |
// |            addr_i   [NUM_PORTS*ADDR_WIDTH]   byte addresses              |
// |            be_i     [NUM_PORTS*DATA_WIDTH/8] byte enables                |
// |            wdata_i/rdata_o [NUM_PORTS*DATA_WIDTH]                        |
// | Options  : SP_RAM_BANK_PARITY_EN - even parity per stored byte, err_o    |
// |            flags a mismatch on read responses; otherwise err_o = 0.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sp_ram_bank_wrap
   import sp_ram_bank_pkg::*;
#(
   parameter int RAM_SIZE   = 32768,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int NUM_BANKS  = 4,
   parameter int NUM_PORTS  = 2,
   parameter int RD_LAT     = 1
) (
   input  logic                              clk,
   input  logic                              rst_i,
   input  logic [NUM_PORTS-1:0]              req_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
   output logic [NUM_PORTS-1:0]              err_o
);

   localparam int NBYTES    = DATA_WIDTH / 8;
   localparam int OFF       = $clog2(NBYTES);
   localparam int BB        = $clog2(NUM_BANKS);
   localparam int BW        = (BB > 0) ? BB : 1;
   localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int NUM_WORDS = RAM_SIZE / NBYTES / NUM_BANKS;
   localparam int ROW_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
`ifdef SP_RAM_BANK_PARITY_EN
   localparam int LANE_W    = 9;
`else
   localparam int LANE_W    = 8;
`endif
   localparam int MEM_W     = NBYTES * LANE_W;

   if (!lat_ok(RD_LAT)) begin : g_bad_lat
      $error("sp_ram_bank_wrap: RD_LAT must be 1 or 2");
   end
   if (!is_pow2(NUM_BANKS)) begin : g_bad_banks
      $error("sp_ram_bank_wrap: NUM_BANKS must be a power of 2");
   end
   if (DATA_WIDTH != RESP_DW) begin : g_bad_width
      $error("sp_ram_bank_wrap: DATA_WIDTH must match the response record width");
   end

   logic [BW-1:0]         port_bank [NUM_PORTS];
   logic [ROW_W-1:0]      port_row  [NUM_PORTS];
   logic [NUM_PORTS-1:0]  bank_req  [NUM_BANKS];
   logic [NUM_PORTS-1:0]  bank_gnt  [NUM_BANKS];
   logic [NUM_BANKS-1:0]  bk_valid;
   logic [NUM_BANKS-1:0]  bk_we;
   logic [NUM_BANKS-1:0]  bk_perr;
   logic [PW-1:0]         bk_win    [NUM_BANKS];
   logic [DATA_WIDTH-1:0] bk_data   [NUM_BANKS];
   resp_t                 resp_s1   [NUM_PORTS];
   resp_t                 resp_out  [NUM_PORTS];

   // Casting to ROW_W drops address bits above RAM_SIZE (modulo wrap).
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_bank[p] = BW'(bank_sel(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]), OFF, BB));
         port_row[p]  = ROW_W'(row_sel(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]), OFF, BB));
      end
   end

   // Requests are masked during reset so nothing is granted or written.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            bank_req[b][p] = req_i[p] & ~rst_i & (port_bank[p] == BW'(b));
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_o = gnt_o | bank_gnt[b];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [PW-1:0]         win;
      logic                  en;
      logic [NUM_PORTS-1:0]  gnt;
      logic                  sel_we;
      logic [ROW_W-1:0]      sel_row;
      logic [NBYTES-1:0]     sel_be;
      logic [DATA_WIDTH-1:0] sel_wdata;
      logic [MEM_W-1:0]      ram_wdata;
      logic [MEM_W-1:0]      ram_rdata;
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_perr;
      logic                  s1_valid;
      logic                  s1_we;
      logic [PW-1:0]         s1_win;

      sp_ram_bank_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
         .clk     (clk),
         .rst_i   (rst_i),
         .req     (bank_req[b]),
         .gnt     (gnt),
         .winner  (win),
         .granted (en)
      );
      assign bank_gnt[b] = gnt;

      // Steer the winning port onto the bank; pack parity beside each byte.
      always_comb begin
         sel_we    = we_i[win];
         sel_row   = port_row[win];
         sel_be    = be_i[win*NBYTES +: NBYTES];
         sel_wdata = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
         ram_wdata = '0;
         for (int k = 0; k < NBYTES; k++) begin
`ifdef SP_RAM_BANK_PARITY_EN
            ram_wdata[k*LANE_W +: LANE_W] = {^sel_wdata[k*8 +: 8], sel_wdata[k*8 +: 8]};
`else
            ram_wdata[k*LANE_W +: LANE_W] = sel_wdata[k*8 +: 8];
`endif
         end
      end

      sp_ram #(
         .NUM_WORDS (NUM_WORDS),
         .LANES     (NBYTES),
         .LANE_W    (LANE_W)
      ) u_ram (
         .clk   (clk),
         .en    (en),
         .we    (sel_we),
         .addr  (sel_row),
         .be    (sel_be),
         .wdata (ram_wdata),
         .rdata (ram_rdata)
      );

      always_comb begin
         rd_data = '0;
         rd_perr = 1'b0;
         for (int k = 0; k < NBYTES; k++) begin
            rd_data[k*8 +: 8] = ram_rdata[k*LANE_W +: 8];
`ifdef SP_RAM_BANK_PARITY_EN
            rd_perr = rd_perr | (^ram_rdata[k*LANE_W +: LANE_W]);
`endif
         end
      end

      // Remember who owns the word the bank returns next cycle.
      always_ff @(posedge clk or posedge rst_i) begin
         if (rst_i) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_win   <= '0;
         end else begin
            s1_valid <= en;
            s1_we    <= sel_we;
            s1_win   <= win;
         end
      end

      assign bk_valid[b] = s1_valid;
      assign bk_we[b]    = s1_we;
      assign bk_win[b]   = s1_win;
      assign bk_data[b]  = rd_data;
      assign bk_perr[b]  = rd_perr;
   end

   // A port owns at most one bank per cycle, so at most one term hits.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         resp_s1[p] = '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bk_valid[b] && (bk_win[b] == PW'(p))) begin
               resp_s1[p].valid = 1'b1;
               resp_s1[p].rdata = bk_we[b] ? '0 : bk_data[b];
               resp_s1[p].err   = ~bk_we[b] & bk_perr[b];
            end
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      resp_t resp_q [NUM_PORTS];
      always_ff @(posedge clk or posedge rst_i) begin
         if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               resp_q[p] <= '0;
            end
         end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               resp_q[p] <= resp_s1[p];
            end
         end
      end
      assign resp_out = resp_q;
   end else begin : g_lat1
      assign resp_out = resp_s1;
   end

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      err_o    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rvalid_o[p]                         = resp_out[p].valid;
         rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = resp_out[p].rdata;
         err_o[p]                            = resp_out[p].err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_bank_wrap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sp_ram_bank_wrap                                           |
// | Purpose  : Self-checking bench for sp_ram_bank_wrap. Two instances share |
// |            the same stimulus: dut1 with RD_LAT=1, dut2 with RD_LAT=2.    |
// |            Table of single transactions plus hand-written sequences for  |
// |            reset, parallel access, conflict, RAW and parity.             |
// | Options  : SP_RAM_BANK_PARITY_EN                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sp_ram_bank_wrap;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int NP = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [NP-1:0]  req;
   logic [NP-1:0]  we;
   logic [NP*AW-1:0] addr;
   logic [NP*4-1:0]  be;
   logic [NP*DW-1:0] wdata;
   logic [NP-1:0]    gnt1, rvalid1, err1, gnt2, rvalid2, err2;
   logic [NP*DW-1:0] rdata1, rdata2;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          port;
      logic        we;
      logic [14:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   sp_ram_bank_wrap #(.RD_LAT(1)) dut1 (
      .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
   );

   sp_ram_bank_wrap #(.RD_LAT(2)) dut2 (
      .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic w, input logic [14:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req[p]            = 1'b1;
      we[p]             = w;
      addr[p*AW +: AW]  = a;
      be[p*4 +: 4]      = b;
      wdata[p*DW +: DW] = d;
   endtask

   // One isolated transaction, checked on both latencies. Starts and ends at posedge+1.
   task automatic do_vec(input string nm, input int p, input logic w, input logic [14:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp, input logic exp_err);
      logic [NP-1:0] oh;
      oh  = NP'(1) << p;
      req = '0;
      drive(p, w, a, b, d);
      #1;
      chk({nm, " gnt1"}, gnt1, oh);
      chk({nm, " gnt2"}, gnt2, oh);
      cyc();
      req = '0;
      #1;
      chk({nm, " rvalid1"}, rvalid1, oh);
      chk({nm, " rdata1"}, rdata1[p*DW +: DW], exp);
      chk({nm, " err1"}, err1[p], exp_err);
      chk({nm, " rvalid2 early"}, rvalid2, 0);
      cyc();
      #1;
      chk({nm, " rvalid2"}, rvalid2, oh);
      chk({nm, " rdata2"}, rdata2[p*DW +: DW], exp);
      chk({nm, " err2"}, err2[p], exp_err);
      chk({nm, " rvalid1 single"}, rvalid1, 0);
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [NP-1:0] g_prev1, g_prev2, g_exp;

      vecs[0]  = '{0, 1'b1, 15'h0020, 4'hF, 32'hFFFFFFFF, 32'h0};
      vecs[1]  = '{1, 1'b1, 15'h0020, 4'h1, 32'h000000AA, 32'h0};
      vecs[2]  = '{0, 1'b0, 15'h0020, 4'h0, 32'h0,        32'hFFFFFFAA};
      vecs[3]  = '{1, 1'b1, 15'h0044, 4'hF, 32'h55667788, 32'h0};
      vecs[4]  = '{0, 1'b1, 15'h0044, 4'h0, 32'h11111111, 32'h0};
      vecs[5]  = '{1, 1'b0, 15'h0044, 4'h0, 32'h0,        32'h55667788};
      vecs[6]  = '{0, 1'b1, 15'h7FFC, 4'hF, 32'hA5A5A5A5, 32'h0};
      vecs[7]  = '{1, 1'b1, 15'h7FFC, 4'h6, 32'h00BBCC00, 32'h0};
      vecs[8]  = '{0, 1'b0, 15'h7FFC, 4'h0, 32'h0,        32'hA5BBCCA5};
      vecs[9]  = '{1, 1'b0, 15'h7FFF, 4'h0, 32'h0,        32'hA5BBCCA5};
      vecs[10] = '{1, 1'b1, 15'h0018, 4'hF, 32'h0F0F0F0F, 32'h0};
      vecs[11] = '{0, 1'b0, 15'h001B, 4'h0, 32'h0,        32'h0F0F0F0F};

      rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset rvalid1", rvalid1, 0);
      chk("reset rdata1", rdata1, 0);
      chk("reset err1", err1, 0);
      chk("reset rvalid2", rvalid2, 0);
      chk("reset rdata2", rdata2, 0);
      chk("reset err2", err2, 0);
      cyc();

      // Conflict on bank 0 straight after reset: pointer starts at port 0.
      g_prev1 = '0;
      g_prev2 = '0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b0, 15'h0010, 4'h0, 32'h0);
         drive(1, 1'b0, 15'h0010, 4'h0, 32'h0);
         #1;
         g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         chk("conflict gnt1", gnt1, g_exp);
         chk("conflict gnt2", gnt2, g_exp);
         chk("conflict rvalid1", rvalid1, g_prev1);
         chk("conflict rvalid2", rvalid2, g_prev2);
         g_prev2 = g_prev1;
         g_prev1 = g_exp;
         cyc();
      end
      req = '0;
      #1;
      chk("conflict tail rvalid1", rvalid1, 2'b10);
      chk("conflict tail rvalid2", rvalid2, 2'b01);
      cyc();
      #1;
      chk("conflict drain rvalid1", rvalid1, 0);
      chk("conflict drain rvalid2", rvalid2, 2'b10);
      cyc();
      #1;
      chk("conflict idle rvalid2", rvalid2, 0);
      cyc();

      for (int i = 0; i < 12; i++) begin
         do_vec($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].be, vecs[i].wdata, vecs[i].exp, 1'b0);
      end

      // Parallel writes to banks 0 and 1, then crossed reads.
      req = '0;
      drive(0, 1'b1, 15'h0000, 4'hF, 32'hDEADBEEF);
      drive(1, 1'b1, 15'h0004, 4'hF, 32'h12345678);
      #1;
      chk("par wr gnt1", gnt1, 2'b11);
      chk("par wr gnt2", gnt2, 2'b11);
      cyc();
      req = '0;
      #1;
      chk("par wr rvalid1", rvalid1, 2'b11);
      chk("par wr rdata1", rdata1, 0);
      cyc();
      #1;
      chk("par wr rvalid2", rvalid2, 2'b11);
      chk("par wr rvalid1 single", rvalid1, 0);
      cyc();
      drive(0, 1'b0, 15'h0004, 4'h0, 32'h0);
      drive(1, 1'b0, 15'h0000, 4'h0, 32'h0);
      #1;
      chk("par rd gnt1", gnt1, 2'b11);
      cyc();
      req = '0;
      #1;
      chk("par rd rvalid1", rvalid1, 2'b11);
      chk("par rd rdata1", rdata1, 64'hDEADBEEF_12345678);
      cyc();
      #1;
      chk("par rd rvalid2", rvalid2, 2'b11);
      chk("par rd rdata2", rdata2, 64'hDEADBEEF_12345678);
      cyc();

      // Read-after-write, back to back on port 0.
      req = '0;
      drive(0, 1'b1, 15'h0040, 4'hF, 32'hCAFEF00D);
      #1;
      chk("raw wr gnt1", gnt1, 2'b01);
      cyc();
      drive(0, 1'b0, 15'h0040, 4'h0, 32'h0);
      #1;
      chk("raw rd gnt1", gnt1, 2'b01);
      chk("raw wr rvalid1", rvalid1, 2'b01);
      chk("raw wr rdata1", rdata1[31:0], 0);
      chk("raw wr rvalid2 early", rvalid2, 0);
      cyc();
      req = '0;
      #1;
      chk("raw rd rvalid1", rvalid1, 2'b01);
      chk("raw rd rdata1", rdata1[31:0], 32'hCAFEF00D);
      chk("raw wr rvalid2", rvalid2, 2'b01);
      chk("raw wr rdata2", rdata2[31:0], 0);
      cyc();
      #1;
      chk("raw rd rvalid1 end", rvalid1, 0);
      chk("raw rd rvalid2", rvalid2, 2'b01);
      chk("raw rd rdata2", rdata2[31:0], 32'hCAFEF00D);
      cyc();
      #1;
      chk("raw rd rvalid2 end", rvalid2, 0);
      cyc();

      // Reset in the middle of a read burst drops every in-flight response.
      req = '0;
      drive(0, 1'b0, 15'h0000, 4'h0, 32'h0);
      cyc();
      drive(0, 1'b0, 15'h0004, 4'h0, 32'h0);
      cyc();
      drive(0, 1'b0, 15'h0008, 4'h0, 32'h0);
      #1;
      rst = 1'b1;
      req = '0;
      #1;
      chk("rst rvalid1", rvalid1, 0);
      chk("rst rvalid2", rvalid2, 0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 2) rst = 1'b0;
         #1;
         chk("rst hold rvalid1", rvalid1, 0);
         chk("rst hold rvalid2", rvalid2, 0);
      end
      cyc();
      do_vec("post-rst rd", 0, 1'b0, 15'h0000, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

      do_vec("par0 wr", 1, 1'b1, 15'h0080, 4'hF, 32'h600DCAFE, 32'h0, 1'b0);
      do_vec("par0 rd", 0, 1'b0, 15'h0080, 4'h0, 32'h0, 32'h600DCAFE, 1'b0);
`ifdef SP_RAM_BANK_PARITY_EN
      dut1.g_bank[0].u_ram.mem[8][3] = ~dut1.g_bank[0].u_ram.mem[8][3];
      dut2.g_bank[0].u_ram.mem[8][3] = ~dut2.g_bank[0].u_ram.mem[8][3];
      do_vec("par1 rd", 0, 1'b0, 15'h0080, 4'h0, 32'h0, 32'h600DCAF6, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
